// File: rtl/counter_seq_ctrl.sv
// Sequencer for a 4-bit clearable counter: runs `reps` passes of 0..term.
// Optional stuck-counter watchdog is enabled by defining CNT_WDOG_EN.
module counter_seq_ctrl #(
    parameter int WIDTH      = 4,
    parameter int PASS_W     = 4,
    parameter int WDOG_LIMIT = 16
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic              stop,
    input  logic [WIDTH-1:0]  term,
    input  logic [PASS_W-1:0] reps,
    input  logic [WIDTH-1:0]  q,
    output logic              cnt_clr,
    output logic              cnt_en,
    output logic              busy,
    output logic [PASS_W-1:0] pass_cnt,
    output logic              done,
    output logic              aborted,
    output logic              err
);

    typedef enum logic [2:0] {IDLE, CLR, RUN, DONE, ABORT} state_t;

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  term_r;
    logic [PASS_W-1:0] reps_r;
    logic [PASS_W-1:0] pass_next;
    logic              accept;
    logic              term_hit;
    logic              wd_trip;

    assign accept    = (state == IDLE) && start;
    assign term_hit  = (q == term_r);
    assign pass_next = pass_cnt + 1'b1;

    // Holding cnt_en low at term_r keeps the counter from stepping past it.
    assign cnt_clr = clear | (state == CLR);
    assign cnt_en  = (state == RUN) && !term_hit;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign aborted = (state == ABORT);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) state_next = (reps == '0) ? DONE : CLR;
            end
            CLR: begin
                state_next = stop ? ABORT : RUN;
            end
            RUN: begin
                if (stop)          state_next = ABORT;
                else if (term_hit) state_next = (pass_next == reps_r) ? DONE : CLR;
                else if (wd_trip)  state_next = ABORT;
            end
            DONE, ABORT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clock) begin
        if (clear) begin
            state    <= IDLE;
            term_r   <= '0;
            reps_r   <= '0;
            pass_cnt <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                term_r   <= term;
                reps_r   <= reps;
                pass_cnt <= '0;
            end else if ((state == RUN) && !stop && term_hit) begin
                pass_cnt <= pass_next;
            end
        end
    end

`ifdef CNT_WDOG_EN
    localparam int WD_W = $clog2(WDOG_LIMIT) + 1;

    logic [WIDTH-1:0] q_prev;
    logic [WD_W-1:0]  wd;
    logic             run_d;
    logic             err_r;

    assign wd_trip = (wd == WD_W'(WDOG_LIMIT - 1));
    assign err     = err_r;

    // NOTE: q_prev is a pure delay of q and needs no reset; the first RUN
    // cycle forces wd to zero, so a stale q_prev is never acted upon.
    always_ff @(posedge clock) begin
        q_prev <= q;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            wd    <= '0;
            run_d <= 1'b0;
            err_r <= 1'b0;
        end else begin
            run_d <= (state == RUN);
            if ((state != RUN) || !run_d || !cnt_en || (q != q_prev)) wd <= '0;
            else                                                      wd <= wd + 1'b1;
            if (accept)                                                  err_r <= 1'b0;
            else if ((state == RUN) && !stop && !term_hit && wd_trip)    err_r <= 1'b1;
        end
    end
`else
    assign wd_trip = 1'b0;
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Scoreboard bench for counter_seq_ctrl: stimulus pushes expected completions
// computed from pass arithmetic, a negedge monitor pops and compares them.
module tb_counter_seq_ctrl;

    logic       clock = 1'b0;
    logic       clear, start, stop;
    logic [3:0] term, reps, q;
    logic       cnt_clr, cnt_en, busy, done, aborted, err;
    logic [3:0] pass_cnt;
    logic       freeze = 1'b0;

    counter_seq_ctrl dut (
        .clock    (clock),
        .clear    (clear),
        .start    (start),
        .stop     (stop),
        .term     (term),
        .reps     (reps),
        .q        (q),
        .cnt_clr  (cnt_clr),
        .cnt_en   (cnt_en),
        .busy     (busy),
        .pass_cnt (pass_cnt),
        .done     (done),
        .aborted  (aborted),
        .err      (err)
    );

    always #5 clock = ~clock;

    // Counter datapath model; freeze pins it at 2 to emulate a dead counter.
    always @(posedge clock) begin
        if (freeze)       q <= 4'd2;
        else if (cnt_clr) q <= 4'd0;
        else if (cnt_en)  q <= q + 4'd1;
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        bit is_abort;
        int cyc;     // absolute cycle of the done/aborted pulse, -1 = unchecked
        int pass;
        int clr;     // cnt_clr pulses in the sequence, -1 = unchecked
        int en;      // cnt_en cycles in the sequence, -1 = unchecked
        int term;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: accumulates per-sequence activity and checks each end pulse.
    int clr_n = 0, en_n = 0, max_q = 0;
    bit end_prev = 0, en_prev = 0;
    always @(negedge clock) begin
        exp_t e;
        if (clear) begin
            clr_n = 0; en_n = 0; max_q = 0; end_prev = 0; en_prev = 0;
        end else begin
            if (end_prev) check("idle_after_end", busy, 0);
            end_prev = done | aborted;
            clr_n += int'(cnt_clr);
            en_n  += int'(cnt_en);
            if (en_prev && int'(q) > max_q) max_q = int'(q);
            en_prev = cnt_en;
            if (done | aborted) begin
                if (sb.size() == 0) begin
                    check("unexpected_end", done | aborted, 0);
                end else begin
                    e = sb.pop_front();
                    check("end_aborted", aborted, e.is_abort);
                    check("end_done", done, !e.is_abort);
                    check("end_pass_cnt", pass_cnt, e.pass);
                    check("q_le_term", max_q <= e.term, 1);
                    if (e.cyc >= 0) check("end_cycle", cyc, e.cyc);
                    if (e.clr >= 0) check("clr_pulses", clr_n, e.clr);
                    if (e.en >= 0)  check("en_cycles", en_n, e.en);
                end
                clr_n = 0; en_n = 0; max_q = 0;
            end
        end
    end

    // One sequence. stop_k >= 0 asserts stop while q==stop_k in pass 1.
    // jitter randomizes start/term/reps while the sequence is busy.
    task automatic run_seq(input int t, input int r, input int stop_k, input bit jitter);
        exp_t e;
        int   last;
        int   cp;
        if (stop_k >= 0) begin
            last = stop_k + 3;
            e = '{1'b1, 0, 0, 1, (stop_k < t) ? stop_k + 1 : t, t};
        end else begin
            last = r * (t + 2) + 1;
            e = '{1'b0, 0, r, r, r * t, t};
        end
        start = 1'b1; stop = 1'b0; term = 4'(t); reps = 4'(r);
        @(posedge clock); #1;
        cp = cyc;
        e.cyc = cp + last - 1;
        sb.push_back(e);
        for (int i = 1; i <= last; i++) begin
            start = jitter ? 1'($urandom_range(0, 1)) : 1'b0;
            if (jitter) begin
                term = 4'($urandom_range(0, 15));
                reps = 4'($urandom_range(0, 15));
            end
            stop = (stop_k >= 0) && (i == stop_k + 2);
            @(posedge clock); #1;
        end
        start = 1'b0; stop = 1'b0;
    endtask

    initial begin
        int t, r, k;
        exp_t w;
        clear = 1'b1; start = 1'b1; stop = 1'b0; term = 4'd7; reps = 4'd3;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_cnt_clr", cnt_clr, 1);
        check("rst_cnt_en", cnt_en, 0);
        check("rst_done", done, 0);
        check("rst_aborted", aborted, 0);
        check("rst_pass_cnt", pass_cnt, 0);
        check("rst_err", err, 0);
        @(posedge clock); #1;
        clear = 1'b0; start = 1'b0;
        @(posedge clock); #1;

        run_seq(3, 2, -1, 0);
        run_seq(5, 0, -1, 0);
        run_seq(0, 3, -1, 0);
        run_seq(15, 1, 5, 0);
        run_seq(2, 2, 2, 0);
        run_seq(3, 1, -1, 1);

        // clear while q==7 in pass 1: back to IDLE, no end pulse
        start = 1'b1; term = 4'd9; reps = 4'd1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (8) begin @(posedge clock); #1; end
        clear = 1'b1;
        @(negedge clock);
        check("clr_mid_cnt_clr", cnt_clr, 1);
        @(posedge clock); #1;
        clear = 1'b0;
        @(negedge clock);
        check("clr_mid_busy", busy, 0);
        check("clr_mid_done", done, 0);
        check("clr_mid_aborted", aborted, 0);
        @(posedge clock); #1;

        // dead counter frozen at 2 with term 9
        freeze = 1'b1;
        @(posedge clock); #1;
        start = 1'b1; term = 4'd9; reps = 4'd1;
        @(posedge clock); #1;
        start = 1'b0;
`ifdef CNT_WDOG_EN
        w = '{1'b1, -1, 0, 1, -1, 9};
        sb.push_back(w);
        repeat (30) begin @(posedge clock); #1; end
        @(negedge clock);
        check("wd_err_set", err, 1);
        check("wd_idle", busy, 0);
        @(posedge clock); #1;
        freeze = 1'b0;
        run_seq(1, 1, -1, 0);
        @(negedge clock);
        check("wd_err_cleared", err, 0);
        @(posedge clock); #1;
`else
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            check("stall_busy", busy, 1);
            check("stall_err", err, 0);
            check("stall_no_end", done | aborted, 0);
            @(posedge clock); #1;
        end
        clear = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0; freeze = 1'b0;
        @(posedge clock); #1;
`endif

        for (int n = 0; n < 25; n++) begin
            t = $urandom_range(0, 15);
            r = $urandom_range(0, 4);
            k = (r > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, t) : -1;
            run_seq(t, r, k, 1);
        end

        repeat (3) @(posedge clock);
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
- Sequencer for the team's 4-bit clearable counter datapath: drives its clear and count-enable, monitors its Q output, and runs a programmed number of count passes from 0 to a terminal value.
- Sits between a command source (start/stop/term/reps) and one counter instance; reports busy, pass progress, completion and abort.

Parameters:
- WIDTH, 4, width of the counter value (term, q).
- PASS_W, 4, width of reps and pass_cnt.
- WDOG_LIMIT, 16, consecutive stuck-count cycles before watchdog abort (used only with the optional feature).

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- clear  in  1  synchronous, active-high reset.
- start  in  1  begin sequence; sampled only in IDLE.
- stop  in  1  abort sequence; sampled in CLR and RUN.
- term  in  WIDTH  terminal count, latched on accepted start.
- reps  in  PASS_W  number of passes, latched on accepted start.
- q  in  WIDTH  current value from the counter.
- cnt_clr  out  1  counter clear.
- cnt_en  out  1  counter count-enable.
- busy  out  1  high in every state except IDLE.
- pass_cnt  out  PASS_W  passes completed in the current sequence.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse on stop (or watchdog) abort.
- err  out  1  sticky watchdog flag (optional feature).

Behaviour:
- Reset (clear=1): state IDLE; term_r, reps_r, pass_cnt = 0; done, aborted, err, cnt_en = 0. cnt_clr = 1 while clear is high, so the counter is cleared together with the controller.
- States: IDLE, CLR, RUN, DONE, ABORT. Outputs are decoded from state: cnt_clr = clear | (state==CLR); cnt_en = (state==RUN) & (q != term_r), so the counter never steps past term_r; done = (state==DONE); aborted = (state==ABORT).
- IDLE: on start=1, latch term and reps and zero pass_cnt. If reps==0, go to DONE. Otherwise go to CLR. start is ignored in every other state.
- CLR: one cycle. If stop=1, go to ABORT; otherwise go to RUN.
- RUN:
  - stop=1 goes to ABORT; stop has priority over term match.
  - Otherwise, on q==term_r, increment pass_cnt. If the incremented value equals reps_r, go to DONE; otherwise go to CLR.
- DONE and ABORT: one cycle each, then IDLE. pass_cnt holds its value until the next accepted start.
- Timing:
  - One pass = 1 CLR cycle + (term_r+1) RUN cycles.
  - With cycle 1 = first cycle after start is sampled, done is high in cycle reps*(term_r+2)+1.
  - cnt_en is high for reps*term_r cycles in total; cnt_clr pulses reps times.
- term_r==0: each pass is CLR plus one RUN cycle, and cnt_en is never asserted.
- term and reps changes after latch are ignored until the next sequence.
- clear mid-sequence returns to IDLE immediately, with no done or aborted pulse.

Optional Feature:
- Macro CNT_WDOG_EN.
- Defined:
  - Register q_prev on every clock.
  - Watchdog counter wd resets on entry to RUN and whenever cnt_en==0 or q!=q_prev. Otherwise it increments, starting from the second RUN cycle.
  - When wd reaches WDOG_LIMIT-1 in RUN, go to ABORT and set err=1.
  - err stays high until the next accepted start or clear.
  - stop and term match in the same cycle take priority over the watchdog.
- Undefined: no q_prev or wd logic; err tied to 0.

Test Plan:
- Reset: clear=1 for 2 cycles with start=1 -> state IDLE, busy=0, cnt_clr=1, cnt_en=0, done=0, pass_cnt=0.
- Normal run: term=3, reps=2, start pulse, healthy counter model -> exactly 2 cnt_clr pulses, cnt_en high for 6 cycles, q never exceeds 3, done high only in cycle 11, pass_cnt=2, busy low from cycle 12.
- Edge values:
  - reps=0 -> done in cycle 1, no cnt_clr, no cnt_en.
  - term=0, reps=3 -> done in cycle 7, cnt_en never high.
- Abort: term=15, reps=1, stop asserted while q==5 -> aborted pulses next cycle, no done, pass_cnt=0; a stop coinciding with q==term also aborts with no pass increment.
- Start while busy / reset mid-run: start pulsed during RUN ignored (term_r unchanged); clear asserted at q==7 -> IDLE next cycle, no done or aborted, cnt_clr high during clear.
- CNT_WDOG_EN: counter model frozen at q=2 with term=9 -> ABORT after 16 stuck cycles, err=1 held until next start; without the macro, same stimulus -> err=0 and the sequence stalls in RUN.
